// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command arbiter: default field widths,
// the R/W bit position and the arbiter FSM encoding.
package spi_pkg;

  localparam int RW_FLAG_W = 1;
  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 8;
  localparam int CMD_W     = RW_FLAG_W + ADDR_W + DATA_W;
  localparam int RW_BIT    = CMD_W - 1;

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_e;

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned k,
                                          input int unsigned n);
    return (ptr + k) % n;
  endfunction

endpackage

// File: rtl/spi_cmd_arbiter_if.sv
// Requester-side and SPI-master-side signals of the command arbiter in one bundle.
interface spi_cmd_arbiter_if
  import spi_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int CMD_WIDTH  = CMD_W,
  parameter int DATA_WIDTH = DATA_W
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*CMD_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [DATA_WIDTH-1:0]        rsp_data;
  logic                         rsp_err;
  logic                         m_cmd_valid;
  logic                         m_cmd_ready;
  logic [CMD_WIDTH-1:0]         m_cmd_data;
  logic                         m_read_valid;
  logic [DATA_WIDTH-1:0]        m_read_data;
  logic                         busy;

  // Arbiter view.
  modport slave (
    input  req_valid, req_data, m_cmd_ready, m_read_valid, m_read_data,
    output req_ready, rsp_valid, rsp_data, rsp_err, m_cmd_valid, m_cmd_data, busy
  );

  // Clients plus SPI master view.
  modport master (
    output req_valid, req_data, m_cmd_ready, m_read_valid, m_read_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err, m_cmd_valid, m_cmd_data, busy
  );

endinterface

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin grant: searches from ptr+1 with wrap, returns
// one-hot grant, its index and whether anything was granted.
module spi_rr_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               gnt_any
);

  int unsigned c;

  always_comb begin
    grant   = '0;
    idx     = '0;
    gnt_any = 1'b0;
    c       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = rr_next(int'(ptr), k, NUM_REQ);
      if (!gnt_any && req[c]) begin
        gnt_any  = 1'b1;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Round-robin sharing of one SPI master between NUM_REQ requesters; ownership
// is held across a read until readback or watchdog timeout.
module spi_cmd_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int RW_FLAG    = RW_FLAG_W,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int CMD_WIDTH  = RW_FLAG + ADDR_WIDTH + DATA_WIDTH,
  parameter int TIMEOUT    = 1024
) (
  input logic              clk,
  input logic              rst_n,
  spi_cmd_arbiter_if.slave bus
);

  localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RW_POS = CMD_WIDTH - 1;

  arb_state_e state, state_nx;

  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ-1:0][CMD_WIDTH-1:0] req_cmd;
  logic [NUM_REQ-1:0]                grant;
  logic [IW-1:0]                     grant_idx;
  logic                              grant_any;
  logic                              m_cmd_valid;
  logic                              rd_done, rd_tmo;

  logic [CMD_WIDTH-1:0]  cmd_q;
  logic [IW-1:0]         owner_q;
  logic [IW-1:0]         rr_ptr;
  logic [CW-1:0]         cnt;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  rsp_err_q;

  assign req_cmd = bus.req_data;

  spi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .grant   (grant),
    .idx     (grant_idx),
    .gnt_any (grant_any)
  );

  // Readback beats the watchdog when both land in the same cycle.
  assign rd_done = (state == WAIT_RD) && bus.m_read_valid;
  assign rd_tmo  = (state == WAIT_RD) && !bus.m_read_valid && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    req_ready   = '0;
    m_cmd_valid = 1'b0;
    case (state)
      ARB: begin
        if (grant_any) begin
          req_ready = grant;
          state_nx  = ISSUE;
        end
      end
      ISSUE: begin
        m_cmd_valid = 1'b1;
        if (bus.m_cmd_ready) state_nx = cmd_q[RW_POS] ? ARB : WAIT_RD;
      end
      WAIT_RD: begin
        if (rd_done || rd_tmo) state_nx = ARB;
      end
      default: state_nx = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= '0;
      owner_q     <= '0;
      rr_ptr      <= IW'(NUM_REQ - 1);
      cnt         <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      if (state == ARB && grant_any) begin
        cmd_q   <= req_cmd[grant_idx];
        owner_q <= grant_idx;
        rr_ptr  <= grant_idx;
      end
      if (state == ISSUE && bus.m_cmd_ready)
        cnt <= '0;
      else if (state == WAIT_RD && cnt != '1)
        cnt <= cnt + 1'b1;
      if (rd_done) begin
        rsp_valid_q[owner_q] <= 1'b1;
        rsp_data_q           <= bus.m_read_data;
        rsp_err_q            <= 1'b0;
      end else if (rd_tmo) begin
        rsp_valid_q[owner_q] <= 1'b1;
        rsp_data_q           <= '0;
        rsp_err_q            <= 1'b1;
      end
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.m_cmd_valid = m_cmd_valid;
  assign bus.m_cmd_data  = cmd_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.busy        = (state != ARB);

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Directed scoreboard bench: stimulus pushes expected grants, commands and
// responses; a negedge monitor pops and compares whatever the DUT presents.
module tb_spi_cmd_arbiter;
  import spi_pkg::*;

  localparam int N  = 2;
  localparam int CW = 12;
  localparam int DW = 8;
  localparam int TO = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_cmd_arbiter_if #(.NUM_REQ(N), .CMD_WIDTH(CW), .DATA_WIDTH(DW)) bus ();

  spi_cmd_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [N-1:0]  vld;
    logic [DW-1:0] data;
    logic          err;
    int            at;
  } rsp_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  int            exp_grant[$];
  logic [CW-1:0] exp_cmd[$];
  rsp_t          exp_rsp[$];
  int            mg;
  logic [CW-1:0] mc;
  rsp_t          mr;
  int            h, g;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.req_ready != '0) begin
        if (exp_grant.size() == 0) chk("unexpected_grant", 32'(bus.req_ready), 32'd0);
        else begin
          mg = exp_grant.pop_front();
          chk("grant", 32'(bus.req_ready), 32'd1 << mg);
        end
      end
      if (bus.m_cmd_valid && bus.m_cmd_ready) begin
        if (exp_cmd.size() == 0) chk("unexpected_cmd", 32'(bus.m_cmd_data), 32'hFFFF);
        else begin
          mc = exp_cmd.pop_front();
          chk("m_cmd_data", 32'(bus.m_cmd_data), 32'(mc));
        end
      end
      if (bus.rsp_valid != '0) begin
        if (exp_rsp.size() == 0) chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
        else begin
          mr = exp_rsp.pop_front();
          chk("rsp_valid", 32'(bus.rsp_valid), 32'(mr.vld));
          chk("rsp_data", 32'(bus.rsp_data), 32'(mr.data));
          chk("rsp_err", 32'(bus.rsp_err), 32'(mr.err));
          chk("rsp_cycle", 32'(cyc), 32'(mr.at));
        end
      end
    end
  end

  task automatic issue(input int idx, input logic [CW-1:0] cmd, output int gc);
    bit ok = 0;
    gc = -1;
    exp_grant.push_back(idx);
    exp_cmd.push_back(cmd);
    bus.req_data[idx*CW +: CW] = cmd;
    bus.req_valid[idx] = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready[idx]) begin ok = 1; gc = cyc; end
    end
    if (!ok) chk("grant_wait_expired", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.req_valid[idx] = 1'b0;
  endtask

  task automatic wait_hs(output int hc);
    bit ok = 0;
    hc = -1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.m_cmd_valid && bus.m_cmd_ready) begin ok = 1; hc = cyc; end
    end
    if (!ok) chk("handshake_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic pulse_read(input logic [DW-1:0] d);
    bus.m_read_valid = 1'b1;
    bus.m_read_data  = d;
    @(posedge clk); #1;
    bus.m_read_valid = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin @(posedge clk); #1; end
  endtask

  task automatic push_rsp(input logic [N-1:0] v, input logic [DW-1:0] d, input logic e,
                          input int at);
    rsp_t r;
    r.vld = v; r.data = d; r.err = e; r.at = at;
    exp_rsp.push_back(r);
  endtask

  // Both requesters hold writes; n grants must follow the listed order.
  task automatic contend(input logic [CW-1:0] c0, input logic [CW-1:0] c1, input int n);
    bit ok;
    for (int k = 0; k < n; k++) begin
      exp_grant.push_back(k % 2);
      exp_cmd.push_back((k % 2 == 0) ? c0 : c1);
    end
    bus.req_data  = {c1, c0};
    bus.req_valid = 2'b11;
    for (int k = 0; k < n; k++) begin
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
        @(negedge clk);
        if (bus.req_ready != '0) ok = 1;
      end
      if (!ok) chk("contend_wait_expired", 32'd0, 32'd1);
      @(posedge clk); #1;
    end
    bus.req_valid = 2'b00;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_m_cmd_valid"}, 32'(bus.m_cmd_valid), 32'd0);
    chk({tag, "_m_cmd_data"}, 32'(bus.m_cmd_data), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
    chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
  endtask

  initial begin
    bus.req_valid    = '0;
    bus.req_data     = '0;
    bus.m_cmd_ready  = 1'b1;
    bus.m_read_valid = 1'b0;
    bus.m_read_data  = '0;
    rst_n            = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Single write from requester 0.
    issue(0, 12'h8A5, g);
    wait_hs(h);
    chk("write_latency", 32'(h), 32'(g + 1));
    @(negedge clk);
    chk("write_back_to_arb", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;

    // Single read from requester 1 with the master briefly stalled.
    bus.m_cmd_ready = 1'b0;
    issue(1, 12'h300, g);
    repeat (2) @(negedge clk);
    chk("stall_cmd_valid", 32'(bus.m_cmd_valid), 32'd1);
    chk("stall_cmd_data", 32'(bus.m_cmd_data), 32'h300);
    @(posedge clk); #1;
    bus.m_cmd_ready = 1'b1;
    wait_hs(h);
    repeat (3) @(posedge clk);
    #1;
    push_rsp(2'b10, 8'h5C, 1'b0, cyc + 1);
    pulse_read(8'h5C);
    repeat (3) @(posedge clk); #1;

    // Watchdog timeout, then a late readback that must be ignored.
    issue(0, 12'h255, g);
    wait_hs(h);
    push_rsp(2'b01, 8'h00, 1'b1, h + TO + 1);
    wait_until(h + TO + 2);
    pulse_read(8'hEE);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("late_read_busy", 32'(bus.busy), 32'd0);
    chk("late_read_data_held", 32'(bus.rsp_data), 32'd0);
    chk("late_read_err_held", 32'(bus.rsp_err), 32'd1);
    @(posedge clk); #1;

    // Readback on the very cycle the watchdog would fire.
    issue(1, 12'h4A1, g);
    wait_hs(h);
    push_rsp(2'b10, 8'hC3, 1'b0, h + TO + 1);
    wait_until(h + TO);
    pulse_read(8'hC3);
    repeat (3) @(posedge clk); #1;

    // Contention after reset: grants alternate starting at 0.
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    contend(12'h811, 12'h922, 4);

    // Reset in the middle of a read.
    issue(0, 12'h1FF, g);
    wait_hs(h);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst");
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk); #1;
    contend(12'hA10, 12'hB20, 2);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("grant_queue_empty", 32'(exp_grant.size()), 32'd0);
    chk("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);
    chk("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
